cache_bus_requester: RTL and testbench

Cache-side bus master for the snooping CommonBus. It accepts one local request at a time from the cache controller: a read-miss fill (BusRd) or a Dragon-style word update (BusUpd). It wins the bus from the arbiter, drives Address, READrWRITE and BusRd/BusUpd, and collects the memory-side data response. It returns the data and the snooped Shared status to the cache controller. It is the initiator counterpart of the memory responder, which drives Data onto the bus and releases it to Z.

---
 rtl/cache_bus_requester_pkg.sv | 23 ++
 rtl/cache_bus_requester_timeout.sv | 29 ++
 rtl/cache_bus_requester.sv | 152 +++++++++++++++
 tb/tb_cache_bus_requester.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_requester_pkg.sv
// Shared bus widths, operation codes and requester state encoding for the cache side.
package CachePackage;

  localparam int unsigned DATABUSWIDTH        = 32;
  localparam int unsigned ADDRESSWIDTH        = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 16;
  // Wide enough for the largest legal timeout (255).
  localparam int unsigned CNT_W               = 8;

  typedef enum logic {
    BUS_RD  = 1'b0,
    BUS_UPD = 1'b1
  } bus_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    ADDR = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } req_state_e;

endpackage

// File: rtl/cache_bus_requester_timeout.sv
// Counts WAIT cycles and flags the last cycle before a read is abandoned.
module req_timeout_counter
  import CachePackage::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYC
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority so the count always starts from zero on WAIT entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc_c = (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/cache_bus_requester.sv
// Cache-side CommonBus master: wins the bus, issues BusRd/BusUpd, returns data and Shared.
module cache_bus_requester
  import CachePackage::*;
#(
  parameter int unsigned DATA_W      = DATABUSWIDTH,
  parameter int unsigned ADDR_W      = ADDRESSWIDTH,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_shared,
  output logic              resp_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_addr_oe,
  output logic              bus_rnw,
  output logic              bus_rd,
  output logic              bus_upd,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              bus_ack,
  input  logic              bus_shared_in
);

  req_state_e        r_state;
  bus_op_e           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_tc;
  logic              w_cnt_clear;
  logic              w_cnt_en;

  assign w_cnt_clear = (r_state != WAIT);
  assign w_cnt_en    = (r_state == WAIT);

  req_timeout_counter #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_tc_c  (w_tc)
  );

  // Request sequencing; every bus and response output is registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_op         <= BUS_RD;
      r_addr       <= '0;
      r_wdata      <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_shared  <= 1'b0;
      resp_err     <= 1'b0;
      bus_req      <= 1'b0;
      bus_addr     <= '0;
      bus_addr_oe  <= 1'b0;
      bus_rnw      <= 1'b0;
      bus_rd       <= 1'b0;
      bus_upd      <= 1'b0;
      bus_data_out <= '0;
      bus_data_oe  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op        <= bus_op_e'(req_op);
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            resp_data   <= '0;
            resp_shared <= 1'b0;
            resp_err    <= 1'b0;
            req_ready   <= 1'b0;
            bus_req     <= 1'b1;
            r_state     <= ARB;
          end
        end
        ARB: begin
          if (bus_gnt) begin
            bus_addr_oe <= 1'b1;
            bus_addr    <= r_addr;
            if (r_op == BUS_UPD) begin
              bus_upd      <= 1'b1;
              bus_rnw      <= 1'b0;
              bus_data_oe  <= 1'b1;
              bus_data_out <= r_wdata;
            end else begin
              bus_rd  <= 1'b1;
              bus_rnw <= 1'b1;
            end
            r_state <= ADDR;
          end
        end
        ADDR: begin
          resp_shared <= resp_shared | bus_shared_in;
          if (r_op == BUS_UPD) begin
            resp_valid   <= 1'b1;
            bus_req      <= 1'b0;
            bus_addr     <= '0;
            bus_addr_oe  <= 1'b0;
            bus_rnw      <= 1'b0;
            bus_rd       <= 1'b0;
            bus_upd      <= 1'b0;
            bus_data_out <= '0;
            bus_data_oe  <= 1'b0;
            r_state      <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          resp_shared <= resp_shared | bus_shared_in;
          if (bus_ack || w_tc) begin
            if (bus_ack) begin
              resp_data <= bus_data_in;
            end else begin
              resp_err <= 1'b1;
            end
            resp_valid  <= 1'b1;
            bus_req     <= 1'b0;
            bus_addr    <= '0;
            bus_addr_oe <= 1'b0;
            bus_rnw     <= 1'b0;
            bus_rd      <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_requester.sv
// Directed bench for cache_bus_requester with a response scoreboard.
module tb_cache_bus_requester;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 4;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_shared;
  logic          resp_err;
  logic          bus_req;
  logic          bus_gnt;
  logic [AW-1:0] bus_addr;
  logic          bus_addr_oe;
  logic          bus_rnw;
  logic          bus_rd;
  logic          bus_upd;
  logic [DW-1:0] bus_data_out;
  logic          bus_data_oe;
  logic [DW-1:0] bus_data_in;
  logic          bus_ack;
  logic          bus_shared_in;

  cache_bus_requester #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_shared   (resp_shared),
    .resp_err      (resp_err),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .bus_addr      (bus_addr),
    .bus_addr_oe   (bus_addr_oe),
    .bus_rnw       (bus_rnw),
    .bus_rd        (bus_rd),
    .bus_upd       (bus_upd),
    .bus_data_out  (bus_data_out),
    .bus_data_oe   (bus_data_oe),
    .bus_data_in   (bus_data_in),
    .bus_ack       (bus_ack),
    .bus_shared_in (bus_shared_in)
  );

  typedef struct {
    int unsigned   lat;
    logic [DW-1:0] data;
    logic          shared;
    logic          err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned acc_hist[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_cnt = 0;
  int unsigned acc_edge = 0;
  logic        saw_doe  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept tracking and response scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (bus_data_oe) saw_doe = 1'b1;
    if (reset_n && req_ready && req_valid) begin
      acc_edge = edge_cnt + 1;
      acc_hist.push_back(acc_edge);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_latency", 64'(edge_cnt + 1 - acc_edge), 64'(e.lat));
        chk("resp_data",    64'(resp_data),   64'(e.data));
        chk("resp_shared",  64'(resp_shared), 64'(e.shared));
        chk("resp_err",     64'(resp_err),    64'(e.err));
        chk("done_enables", {61'd0, bus_req, bus_addr_oe, bus_data_oe}, 64'd0);
      end
    end
  end

  // Presents one request from an IDLE cycle; returns 1 time unit after the accept edge.
  task automatic send(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b1;
    req_valid     = 1'b0;
    req_op        = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    bus_gnt       = 1'b1;
    bus_data_in   = '0;
    bus_ack       = 1'b0;
    bus_shared_in = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_req_ready",   64'(req_ready),   64'd1);
    chk("rst_resp",        {60'd0, resp_valid, resp_shared, resp_err, |resp_data}, 64'd0);
    chk("rst_bus_ctrl",    {58'd0, bus_req, bus_addr_oe, bus_data_oe, bus_rd, bus_upd, bus_rnw}, 64'd0);
    chk("rst_bus_addr",    64'(bus_addr),     64'd0);
    chk("rst_bus_dout",    64'(bus_data_out), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Read, happy path: grant immediate, ack on WAIT cycle 3.
    exp_q.push_back('{lat: 6, data: 32'hDEADBEEF, shared: 1'b0, err: 1'b0});
    send(1'b0, 16'h1234, 32'h0);
    chk("rd_arb_req",   64'(bus_req),     64'd1);
    chk("rd_arb_oe",    64'(bus_addr_oe), 64'd0);
    chk("rd_arb_ready", 64'(req_ready),   64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (i == 3) begin
        bus_ack     = 1'b1;
        bus_data_in = 32'hDEADBEEF;
      end
      chk("rd_addr_oe",  64'(bus_addr_oe), 64'd1);
      chk("rd_addr",     64'(bus_addr),    64'h1234);
      chk("rd_busrd",    {62'd0, bus_rd, bus_rnw}, 64'd3);
      chk("rd_no_data",  64'(bus_data_oe), 64'd0);
    end
    @(posedge clock);
    #1;
    bus_ack     = 1'b0;
    bus_data_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rd_hold_data",  64'(resp_data),  64'hDEADBEEF);
    chk("rd_idle_ready", 64'(req_ready),  64'd1);

    // Update with Shared asserted during ADDR.
    exp_q.push_back('{lat: 3, data: 32'h0, shared: 1'b1, err: 1'b0});
    send(1'b1, 16'h00F0, 32'hA5A5A5A5);
    chk("upd_arb_doe", 64'(bus_data_oe), 64'd0);
    @(posedge clock);
    #1;
    bus_shared_in = 1'b1;
    chk("upd_doe",   {62'd0, bus_data_oe, bus_upd}, 64'd3);
    chk("upd_dout",  64'(bus_data_out), 64'hA5A5A5A5);
    chk("upd_addr",  64'(bus_addr),     64'h00F0);
    chk("upd_rnw",   64'(bus_rnw),      64'd0);
    @(posedge clock);
    #1;
    bus_shared_in = 1'b0;
    chk("upd_doe_off", {62'd0, bus_data_oe, bus_upd}, 64'd0);
    repeat (2) @(posedge clock);
    #1;

    // Timeout: read with no ack.
    exp_q.push_back('{lat: 7, data: 32'h0, shared: 1'b0, err: 1'b1});
    send(1'b0, 16'h0BAD, 32'h0);
    repeat (8) @(posedge clock);
    #1;
    chk("to_err_hold", 64'(resp_err), 64'd1);

    // Reset asserted during the second WAIT cycle.
    send(1'b0, 16'h0777, 32'h0);
    repeat (3) @(posedge clock);
    #2;
    chk("rstw_pre_oe", 64'(bus_addr_oe), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstw_release", {61'd0, bus_addr_oe, bus_req, bus_rd}, 64'd0);
    chk("rstw_ready",   64'(req_ready), 64'd1);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rstw_ready_after", 64'(req_ready), 64'd1);

    // Back-to-back reads with req_valid held and ack permanently high.
    exp_q.push_back('{lat: 4, data: 32'hCAFE0001, shared: 1'b0, err: 1'b0});
    exp_q.push_back('{lat: 4, data: 32'hCAFE0002, shared: 1'b0, err: 1'b0});
    acc_hist.delete();
    saw_doe     = 1'b0;
    bus_ack     = 1'b1;
    bus_data_in = 32'hCAFE0001;
    req_valid   = 1'b1;
    req_op      = 1'b0;
    req_addr    = 16'h0100;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1 bus_data_in = 32'hCAFE0002;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    bus_ack     = 1'b0;
    bus_data_in = '0;
    chk("b2b_accepts", 64'(acc_hist.size()), 64'd2);
    if (acc_hist.size() >= 2) chk("b2b_spacing", 64'(acc_hist[1] - acc_hist[0]), 64'd5);
    chk("b2b_no_doe", 64'(saw_doe), 64'd0);

    // Grant stalled for 20 ARB cycles, then a read that times out.
    exp_q.push_back('{lat: 27, data: 32'h0, shared: 1'b0, err: 1'b1});
    bus_gnt = 1'b0;
    send(1'b0, 16'h0F0F, 32'h0);
    for (int i = 0; i < 20; i++) begin
      chk("stall_req", 64'(bus_req), 64'd1);
      chk("stall_en",  {61'd0, bus_addr_oe, bus_data_oe, bus_rd}, 64'd0);
      @(posedge clock);
      #1;
    end
    bus_gnt = 1'b1;
    repeat (8) @(posedge clock);
    #1;

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
